mismatch_tracker: RTL and testbench

MISMATCH_TRACKER -- requirements
Module: mismatch_tracker

---
 rtl/mismatch_tracker_if.sv | 35 +++
 rtl/mismatch_tracker.sv | 130 +++++++++++++
 tb/tb_mismatch_tracker.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/mismatch_tracker_if.sv
// Sample/result bus for mismatch_tracker: window control, compared vectors,
// counters and the result handshake.
interface mismatch_tracker_if #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 16
);
  logic             start;
  logic             stop;
  logic             sample_en;
  logic [WIDTH-1:0] ref_val;
  logic [WIDTH-1:0] dut_val;
  logic             busy;
  logic [CNT_W-1:0] samples;
  logic [CNT_W-1:0] errors;
  logic [CNT_W-1:0] first_err_idx;
  logic             first_err_valid;
  logic [WIDTH-1:0] err_mask;
  logic             res_valid;
  logic             res_ready;
  logic             pass;

  // Stimulus/consumer side.
  modport master (
    output start, stop, sample_en, ref_val, dut_val, res_ready,
    input  busy, samples, errors, first_err_idx, first_err_valid,
           err_mask, res_valid, pass
  );

  // Tracker side.
  modport slave (
    input  start, stop, sample_en, ref_val, dut_val, res_ready,
    output busy, samples, errors, first_err_idx, first_err_valid,
           err_mask, res_valid, pass
  );
endinterface

// File: rtl/mismatch_tracker.sv
// mismatch_tracker: counts qualified samples and mismatches between a
// reference and an observed vector inside a start/stop window, then presents
// a held verdict through a valid/ready result handshake.
module mismatch_tracker #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic            clk,
  input  logic            aresetn,
  mismatch_tracker_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t           state_q, state_nx;
  logic [1:0]       rst_sync_q;
  logic             rst_n;

  logic [CNT_W-1:0] samples_q, samples_nx;
  logic [CNT_W-1:0] errors_q, errors_nx;
  logic [CNT_W-1:0] first_idx_q, first_idx_nx;
  logic             first_vld_q, first_vld_nx;
  logic [WIDTH-1:0] mask_q, mask_nx;
  logic             pass_q, pass_nx;
  logic [WIDTH-1:0] diff;
  logic             mismatch;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // Reset synchroniser: assertion is immediate, release waits two clk edges
  // so every state flop leaves reset on a clean edge.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) rst_sync_q <= '0;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_nx;
  end

  // Next-state and next-result computation.
  always_comb begin
    state_nx     = state_q;
    samples_nx   = samples_q;
    errors_nx    = errors_q;
    first_idx_nx = first_idx_q;
    first_vld_nx = first_vld_q;
    mask_nx      = mask_q;
    pass_nx      = pass_q;
    diff         = bus.ref_val ^ bus.dut_val;
    mismatch     = bus.sample_en && (diff != '0);

    case (state_q)
      IDLE: begin
        // start wins over a simultaneous stop; stop alone does nothing.
        if (bus.start) begin
          samples_nx   = '0;
          errors_nx    = '0;
          first_idx_nx = '0;
          first_vld_nx = 1'b0;
          mask_nx      = '0;
          pass_nx      = 1'b0;
          state_nx     = RUN;
        end
      end
      RUN: begin
        if (bus.sample_en) begin
          samples_nx = sat_inc(samples_q);
          if (mismatch) begin
            errors_nx = sat_inc(errors_q);
            mask_nx   = mask_q | diff;
            // Index is the pre-increment count (saturated value if counter is full).
            if (!first_vld_q) begin
              first_idx_nx = samples_q;
              first_vld_nx = 1'b1;
            end
          end
        end
        // Verdict uses the counts including any sample taken in the stop cycle.
        if (bus.stop) begin
          pass_nx  = (errors_nx == '0) && (samples_nx != '0);
          state_nx = REPORT;
        end
      end
      REPORT: begin
        if (bus.res_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Result registers; held across REPORT and the following IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samples_q   <= '0;
      errors_q    <= '0;
      first_idx_q <= '0;
      first_vld_q <= 1'b0;
      mask_q      <= '0;
      pass_q      <= 1'b0;
    end else begin
      samples_q   <= samples_nx;
      errors_q    <= errors_nx;
      first_idx_q <= first_idx_nx;
      first_vld_q <= first_vld_nx;
      mask_q      <= mask_nx;
      pass_q      <= pass_nx;
    end
  end

  assign bus.busy            = (state_q == RUN);
  assign bus.res_valid       = (state_q == REPORT);
  assign bus.samples         = samples_q;
  assign bus.errors          = errors_q;
  assign bus.first_err_idx   = first_idx_q;
  assign bus.first_err_valid = first_vld_q;
  assign bus.err_mask        = mask_q;
  assign bus.pass            = pass_q;

endmodule

// File: tb/tb_mismatch_tracker.sv
// Directed bench for mismatch_tracker: a wide-counter instance (u_a) and a
// 4-bit-counter instance (u_b) share the same stimulus.
module tb_mismatch_tracker;

  logic       clk = 1'b0;
  logic       aresetn = 1'b0;
  logic       start = 1'b0, stop = 1'b0, sample_en = 1'b0, res_ready = 1'b0;
  logic [3:0] ref_val = '0, dut_val = '0;
  int         n_total = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;

  mismatch_tracker_if #(.WIDTH(4), .CNT_W(16)) if_a ();
  mismatch_tracker_if #(.WIDTH(4), .CNT_W(4))  if_b ();

  assign if_a.start = start;  assign if_a.stop = stop;
  assign if_a.sample_en = sample_en;  assign if_a.res_ready = res_ready;
  assign if_a.ref_val = ref_val;  assign if_a.dut_val = dut_val;
  assign if_b.start = start;  assign if_b.stop = stop;
  assign if_b.sample_en = sample_en;  assign if_b.res_ready = res_ready;
  assign if_b.ref_val = ref_val;  assign if_b.dut_val = dut_val;

  mismatch_tracker #(.WIDTH(4), .CNT_W(16)) u_a (.clk(clk), .aresetn(aresetn), .bus(if_a));
  mismatch_tracker #(.WIDTH(4), .CNT_W(4))  u_b (.clk(clk), .aresetn(aresetn), .bus(if_b));

  typedef struct {
    logic        st, sp, en;
    logic [3:0]  rv, dv;
    logic        rdy;
    logic        busy, resv;
    logic [15:0] smp, err, fidx;
    logic        fv;
    logic [3:0]  mask;
    logic        pass;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drive one cycle of inputs; returns at the next falling edge.
  task automatic drv(input logic st, input logic sp, input logic en,
                     input logic [3:0] r, input logic [3:0] d, input logic rdy);
    start = st; stop = sp; sample_en = en; ref_val = r; dut_val = d; res_ready = rdy;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(0, 0, 0, 4'h0, 4'h0, 0);
  endtask

  task automatic ack();
    drv(0, 0, 0, 4'h0, 4'h0, 1);
    chk("ack_resv", 32'(if_a.res_valid), 32'd0);
  endtask

  initial begin
    // Mismatches at index 3 (diff 0001) and 7 (diff 1000); stop with sample 9.
    tbl[0]  = '{1,0,0,4'h5,4'h5,0, 1,0,16'd0, 16'd0,16'd0,0,4'h0,0};
    tbl[1]  = '{0,0,1,4'h5,4'h5,0, 1,0,16'd1, 16'd0,16'd0,0,4'h0,0};
    tbl[2]  = '{0,0,1,4'h5,4'h5,0, 1,0,16'd2, 16'd0,16'd0,0,4'h0,0};
    tbl[3]  = '{0,0,1,4'h5,4'h5,0, 1,0,16'd3, 16'd0,16'd0,0,4'h0,0};
    tbl[4]  = '{0,0,1,4'h5,4'h4,0, 1,0,16'd4, 16'd1,16'd3,1,4'h1,0};
    tbl[5]  = '{0,0,1,4'h5,4'h5,0, 1,0,16'd5, 16'd1,16'd3,1,4'h1,0};
    tbl[6]  = '{0,0,1,4'h5,4'h5,0, 1,0,16'd6, 16'd1,16'd3,1,4'h1,0};
    tbl[7]  = '{0,0,1,4'h5,4'h5,0, 1,0,16'd7, 16'd1,16'd3,1,4'h1,0};
    tbl[8]  = '{0,0,1,4'h5,4'hD,0, 1,0,16'd8, 16'd2,16'd3,1,4'h9,0};
    tbl[9]  = '{0,0,1,4'h5,4'h5,0, 1,0,16'd9, 16'd2,16'd3,1,4'h9,0};
    tbl[10] = '{0,1,1,4'h5,4'h5,0, 0,1,16'd10,16'd2,16'd3,1,4'h9,0};
    tbl[11] = '{0,1,1,4'h5,4'h0,0, 0,1,16'd10,16'd2,16'd3,1,4'h9,0};
    tbl[12] = '{1,0,1,4'h5,4'h0,1, 0,0,16'd10,16'd2,16'd3,1,4'h9,0};
    tbl[13] = '{0,0,0,4'h0,4'h0,0, 0,0,16'd10,16'd2,16'd3,1,4'h9,0};

    // Reset state.
    idle(3);
    chk("rst_busy", 32'(if_a.busy), 32'd0);
    chk("rst_resv", 32'(if_a.res_valid), 32'd0);
    chk("rst_samples", 32'(if_a.samples), 32'd0);
    chk("rst_pass", 32'(if_a.pass), 32'd0);
    aresetn = 1'b1;
    idle(3);

    // Table-driven window.
    for (int i = 0; i < 14; i++) begin
      drv(tbl[i].st, tbl[i].sp, tbl[i].en, tbl[i].rv, tbl[i].dv, tbl[i].rdy);
      chk($sformatf("v%0d_busy", i),  32'(if_a.busy), 32'(tbl[i].busy));
      chk($sformatf("v%0d_resv", i),  32'(if_a.res_valid), 32'(tbl[i].resv));
      chk($sformatf("v%0d_samples", i), 32'(if_a.samples), 32'(tbl[i].smp));
      chk($sformatf("v%0d_errors", i), 32'(if_a.errors), 32'(tbl[i].err));
      chk($sformatf("v%0d_fidx", i),  32'(if_a.first_err_idx), 32'(tbl[i].fidx));
      chk($sformatf("v%0d_fvalid", i), 32'(if_a.first_err_valid), 32'(tbl[i].fv));
      chk($sformatf("v%0d_mask", i),  32'(if_a.err_mask), 32'(tbl[i].mask));
      chk($sformatf("v%0d_pass", i),  32'(if_a.pass), 32'(tbl[i].pass));
    end

    // 20 matching samples.
    drv(1, 0, 0, 4'h1, 4'h1, 0);
    for (int i = 0; i < 20; i++) drv(0, 0, 1, 4'h1, 4'h1, 0);
    drv(0, 1, 0, 4'h1, 4'h1, 0);
    chk("m20_samples", 32'(if_a.samples), 32'd20);
    chk("m20_errors", 32'(if_a.errors), 32'd0);
    chk("m20_fvalid", 32'(if_a.first_err_valid), 32'd0);
    chk("m20_pass", 32'(if_a.pass), 32'd1);
    chk("m20_resv", 32'(if_a.res_valid), 32'd1);
    chk("m20_b_samples", 32'(if_b.samples), 32'd15);
    chk("m20_b_pass", 32'(if_b.pass), 32'd1);
    ack();

    // 20 mismatching samples, saturation on the narrow counters.
    drv(1, 0, 0, 4'h0, 4'h0, 0);
    for (int i = 0; i < 20; i++) drv(0, 0, 1, 4'h0, 4'h3, 0);
    drv(0, 1, 0, 4'h0, 4'h0, 0);
    chk("sat_b_samples", 32'(if_b.samples), 32'd15);
    chk("sat_b_errors", 32'(if_b.errors), 32'd15);
    chk("sat_b_fidx", 32'(if_b.first_err_idx), 32'd0);
    chk("sat_b_fvalid", 32'(if_b.first_err_valid), 32'd1);
    chk("sat_b_mask", 32'(if_b.err_mask), 32'h3);
    chk("sat_b_pass", 32'(if_b.pass), 32'd0);
    chk("sat_a_samples", 32'(if_a.samples), 32'd20);
    chk("sat_a_errors", 32'(if_a.errors), 32'd20);
    ack();

    // First mismatch only after the narrow sample counter saturated.
    drv(1, 0, 0, 4'h0, 4'h0, 0);
    for (int i = 0; i < 17; i++) drv(0, 0, 1, 4'h1, 4'h1, 0);
    drv(0, 1, 1, 4'h1, 4'h0, 0);
    chk("late_b_samples", 32'(if_b.samples), 32'd15);
    chk("late_b_fidx", 32'(if_b.first_err_idx), 32'd15);
    chk("late_b_errors", 32'(if_b.errors), 32'd1);
    chk("late_b_mask", 32'(if_b.err_mask), 32'h1);
    chk("late_a_samples", 32'(if_a.samples), 32'd18);
    chk("late_a_fidx", 32'(if_a.first_err_idx), 32'd17);
    ack();

    // Empty window; REPORT holds under back-pressure and ignores inputs.
    drv(1, 0, 0, 4'h0, 4'h0, 0);
    drv(0, 1, 0, 4'h0, 4'h0, 0);
    chk("empty_samples", 32'(if_a.samples), 32'd0);
    chk("empty_pass", 32'(if_a.pass), 32'd0);
    chk("empty_resv", 32'(if_a.res_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      drv(i[0], ~i[0], 1, 4'h0, 4'hF, 0);
      chk($sformatf("hold%0d_resv", i), 32'(if_a.res_valid), 32'd1);
      chk($sformatf("hold%0d_busy", i), 32'(if_a.busy), 32'd0);
      chk($sformatf("hold%0d_errs", i), 32'(if_a.errors), 32'd0);
      chk($sformatf("hold%0d_samples", i), 32'(if_a.samples), 32'd0);
    end
    ack();
    idle(1);
    chk("empty_idle_busy", 32'(if_a.busy), 32'd0);

    // start during RUN is ignored; start+stop in IDLE is a start.
    drv(1, 0, 0, 4'h0, 4'h0, 0);
    for (int i = 0; i < 3; i++) drv(0, 0, 1, 4'h2, 4'h2, 0);
    drv(1, 0, 1, 4'h2, 4'h2, 0);
    chk("rstart_busy", 32'(if_a.busy), 32'd1);
    chk("rstart_samples", 32'(if_a.samples), 32'd4);
    drv(0, 1, 0, 4'h0, 4'h0, 0);
    chk("rstart_final", 32'(if_a.samples), 32'd4);
    ack();
    drv(1, 1, 0, 4'h0, 4'h0, 0);
    chk("ss_busy", 32'(if_a.busy), 32'd1);
    chk("ss_resv", 32'(if_a.res_valid), 32'd0);
    chk("ss_samples", 32'(if_a.samples), 32'd0);
    drv(0, 1, 0, 4'h0, 4'h0, 0);
    ack();

    // Asynchronous reset mid-RUN, then a fresh window.
    drv(1, 0, 0, 4'h0, 4'h0, 0);
    for (int i = 0; i < 5; i++) drv(0, 0, 1, 4'h6, 4'h7, 0);
    chk("pre_rst_samples", 32'(if_a.samples), 32'd5);
    aresetn = 1'b0;
    #1;
    chk("arst_busy", 32'(if_a.busy), 32'd0);
    chk("arst_samples", 32'(if_a.samples), 32'd0);
    chk("arst_errors", 32'(if_a.errors), 32'd0);
    chk("arst_fvalid", 32'(if_a.first_err_valid), 32'd0);
    chk("arst_mask", 32'(if_a.err_mask), 32'd0);
    chk("arst_b_busy", 32'(if_b.busy), 32'd0);
    @(negedge clk);
    idle(1);
    aresetn = 1'b1;
    idle(3);
    drv(1, 0, 0, 4'h0, 4'h0, 0);
    for (int i = 0; i < 3; i++) drv(0, 0, 1, 4'h9, 4'h9, 0);
    drv(0, 1, 0, 4'h0, 4'h0, 0);
    chk("post_rst_samples", 32'(if_a.samples), 32'd3);
    chk("post_rst_pass", 32'(if_a.pass), 32'd1);
    chk("post_rst_resv", 32'(if_a.res_valid), 32'd1);
    ack();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
